pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline register that sits between the ID, EX and MEM stage blocks of the pipelined RISC-V core. It carries an opaque stage payload: PC, immediate, control fields and operands are packed by the instantiating stage. Each instance provides a valid/ready handshake, hazard stall, branch flush with bubble insertion, and an optional skid slot so that in_ready is registered. Saturating stall and flush counters support performance debug.

Parameters:
DATA_W, 128, payload width in bits.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
BUBBLE, {DATA_W{1'b0}}, value driven on out_data whenever out_valid=0.
CNT_W, 16, width of the stall and flush counters.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream beat valid.
in_ready  output  1  stage can accept a beat this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  registered beat valid.
out_ready  input  1  downstream accepts.
out_data  output  DATA_W  registered payload, or BUBBLE when invalid.
stall  input  1  hazard-unit hold; forces effective downstream ready low.
flush  input  1  kill all held beats and any beat accepted this cycle.
occupancy  output  2  number of held beats (0..2; never exceeds 1 when SKID=0).
stall_cnt  output  CNT_W  cycles with out_valid=1 and no downstream transfer.
flush_cnt  output  CNT_W  flush cycles that killed at least one valid beat.

Behaviour:
- Interface decided: one clock clk; reset rst_n, asynchronous, active-low.
- Reset values (asserted asynchronously, released on next edge): out_valid=0, skid slot empty, out_data=BUBBLE, occupancy=0, stall_cnt=0, flush_cnt=0, in_ready=1 when SKID=1.
- Definitions:
  - dn_go = out_valid & out_ready & ~stall.
  - up_go = in_valid & in_ready.
- Latency: 1 cycle from up_go to out_valid when the main register is empty or draining; throughput of 1 beat per cycle when not stalled.
- SKID=0:
  - in_ready = (~out_valid | (out_ready & ~stall)), combinational.
  - Main register loads on up_go.
- SKID=1:
  - in_ready = ~skid_valid, a pure register output.
  - up_go while main is full and not draining writes the skid slot.
  - On dn_go with skid full, skid moves to main and the new up_go beat (if any) refills skid.
  - When both drain and refill happen in one cycle, order is main <- skid, skid <- in.
  - FIFO order is always preserved; a beat never overtakes another.
- Full condition (SKID=1): occupancy=2 forces in_ready=0 the next cycle. No beat is ever dropped except by flush.
- Empty condition: out_valid=0 and out_data=BUBBLE. out_ready is ignored.
- Stall: out_valid and out_data are held stable. With SKID=1, one further beat is accepted into skid, then in_ready drops.
- Flush (highest priority):
  - Next cycle: out_valid=0, skid empty, out_data=BUBBLE.
  - A beat accepted in the flush cycle (up_go=1) is discarded.
  - Flush with simultaneous dn_go: the downstream transfer still completes this cycle.
  - Flush with simultaneous stall: flush wins.
- Counters:
  - stall_cnt +1 when out_valid & ~dn_go.
  - flush_cnt +1 when flush & (occupancy!=0).
  - Both saturate at all-ones and never wrap.
  - Both clear only on reset.
- Reset mid-operation: all state clears immediately. Beats in flight are lost.
- out_data is invariant while out_valid=1 and no dn_go occurs.

Decomposition:
- Shared package pipe_pkg:
  - localparams for payload field offsets per stage (ID_EX_W, EX_MEM_W, MEM_WB_W).
  - NOP payload constant BUBBLE_NOP with RegWrite=0 and MemWrite=0.
  - Counter width default.
- Sub-module: sat_counter (CNT_W, inc, count), instantiated twice.

Test Plan:
1. Reset and empty: deassert rst_n after 3 cycles, in_valid=0 -> out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=1, counters=0.
2. Streaming: SKID=1, out_ready=1, push 0x1..0x8 back-to-back -> 0x1..0x8 appear in order starting 1 cycle after the first push, one per cycle; in_ready stays 1.
3. Backpressure and skid: out_ready=0 while pushing 0xA, 0xB, 0xC -> 0xA and 0xB held, in_ready=0 after 0xB, 0xC not accepted. Raise out_ready -> 0xA, 0xB, then 0xC in order; stall_cnt equals the number of held cycles.
4. Flush: occupancy=2 (0x10, 0x11), flush=1 with in_valid=1 carrying 0x12 -> next cycle out_valid=0, occupancy=0, out_data=BUBBLE; 0x12 never appears; flush_cnt=1.
5. Stall vs flush: stall=1 and flush=1 in the same cycle with 0x20 held -> 0x20 is killed and flush_cnt increments. Stall alone for 5 cycles -> 0x20 stable and stall_cnt +5.
6. Saturation and async reset: CNT_W=4, stall for 20 cycles -> stall_cnt=15. Pulse rst_n low mid-cycle -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers of the RISC-V core.
// Holds the per-stage payload layouts, the NOP payload used as a bubble and
// the default width of the stall/flush performance counters.
package pipe_pkg;

    // Default width of the saturating performance counters.
    localparam int CNT_W_DEFAULT = 16;

    // Common field widths.
    localparam int XLEN  = 32;
    localparam int CTRL_W = 8;
    localparam int RD_W   = 5;

    // Control byte bit positions, identical in every stage payload.
    localparam int CTRL_REGWRITE_BIT = 0;
    localparam int CTRL_MEMWRITE_BIT = 1;
    localparam int CTRL_MEMREAD_BIT  = 2;

    // ID/EX payload: ctrl | rd | pc | imm | rs1 | rs2 (LSB first).
    localparam int ID_EX_CTRL_LSB = 0;
    localparam int ID_EX_RD_LSB   = ID_EX_CTRL_LSB + CTRL_W;
    localparam int ID_EX_PC_LSB   = ID_EX_RD_LSB + RD_W;
    localparam int ID_EX_IMM_LSB  = ID_EX_PC_LSB + XLEN;
    localparam int ID_EX_RS1_LSB  = ID_EX_IMM_LSB + XLEN;
    localparam int ID_EX_RS2_LSB  = ID_EX_RS1_LSB + XLEN;
    localparam int ID_EX_W        = ID_EX_RS2_LSB + XLEN;

    // EX/MEM payload: ctrl | rd | alu result | store data.
    localparam int EX_MEM_CTRL_LSB = 0;
    localparam int EX_MEM_RD_LSB   = EX_MEM_CTRL_LSB + CTRL_W;
    localparam int EX_MEM_ALU_LSB  = EX_MEM_RD_LSB + RD_W;
    localparam int EX_MEM_STD_LSB  = EX_MEM_ALU_LSB + XLEN;
    localparam int EX_MEM_W        = EX_MEM_STD_LSB + XLEN;

    // MEM/WB payload: ctrl | rd | writeback result.
    localparam int MEM_WB_CTRL_LSB = 0;
    localparam int MEM_WB_RD_LSB   = MEM_WB_CTRL_LSB + CTRL_W;
    localparam int MEM_WB_RES_LSB  = MEM_WB_RD_LSB + RD_W;
    localparam int MEM_WB_W        = MEM_WB_RES_LSB + XLEN;

    // NOP payload: every control bit clear, so RegWrite=0 and MemWrite=0.
    localparam logic [ID_EX_W-1:0] BUBBLE_NOP = {ID_EX_W{1'b0}};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug.
// Ports: clk, rst_n (async active-low), inc (count this cycle),
//        count (current value, sticks at all-ones, clears only on reset).
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;

    // Next count: increment unless already saturated.
    always_comb begin
        count_nxt_s = count_r;
        if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline register between core stages with valid/ready handshake, hazard
// stall, branch flush and an optional skid slot (registered in_ready).
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream (out_data = BUBBLE when
//        invalid); stall, flush control; occupancy (held beats);
//        stall_cnt, flush_cnt saturating debug counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 128,
    parameter int                SKID   = 1,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
    parameter int                CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic SKID_EN = (SKID != 0);

    logic              main_valid_r;
    logic [DATA_W-1:0] main_data_r;
    logic              skid_valid_r;
    logic [DATA_W-1:0] skid_data_r;

    logic              main_valid_nxt_s;
    logic [DATA_W-1:0] main_data_nxt_s;
    logic              skid_valid_nxt_s;
    logic [DATA_W-1:0] skid_data_nxt_s;

    logic dn_go_s;
    logic up_go_s;
    logic in_ready_s;
    logic stall_inc_s;
    logic flush_inc_s;

    assign dn_go_s = main_valid_r & out_ready & ~stall;

    // With the skid slot, readiness depends only on a register; without it,
    // a full main register can accept only while it drains this cycle.
    assign in_ready_s = SKID_EN ? ~skid_valid_r
                                : (~main_valid_r | (out_ready & ~stall));
    assign up_go_s    = in_valid & in_ready_s;

    // Next-state of main register and skid slot. The skid slot is only ever
    // occupied while main is, so an empty main implies an empty skid.
    // main_data holds BUBBLE whenever main is empty so out_data is a plain
    // register output.
    always_comb begin
        main_valid_nxt_s = main_valid_r;
        main_data_nxt_s  = main_data_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_data_nxt_s  = skid_data_r;
        if (flush) begin
            // Kills held beats and any beat accepted this cycle.
            main_valid_nxt_s = 1'b0;
            main_data_nxt_s  = BUBBLE;
            skid_valid_nxt_s = 1'b0;
            skid_data_nxt_s  = BUBBLE;
        end else if (!main_valid_r) begin
            if (up_go_s) begin
                main_valid_nxt_s = 1'b1;
                main_data_nxt_s  = in_data;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else if (dn_go_s) begin
            if (skid_valid_r) begin
                // Drain and refill together: main <- skid, skid <- in.
                main_data_nxt_s  = skid_data_r;
                skid_valid_nxt_s = up_go_s & SKID_EN;
                if (up_go_s) begin
                    skid_data_nxt_s = in_data;
                end else begin
                    skid_data_nxt_s = skid_data_r;
                end
            end else if (up_go_s) begin
                main_data_nxt_s = in_data;
            end else begin
                main_valid_nxt_s = 1'b0;
                main_data_nxt_s  = BUBBLE;
            end
        end else begin
            // Main held: an accepted beat parks in the skid slot.
            if (up_go_s) begin
                skid_valid_nxt_s = SKID_EN;
                skid_data_nxt_s  = in_data;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // Main register and skid slot state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            main_data_r  <= BUBBLE;
            skid_valid_r <= 1'b0;
            skid_data_r  <= BUBBLE;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            main_data_r  <= main_data_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
        end
    end

    assign stall_inc_s = main_valid_r & ~dn_go_s;
    assign flush_inc_s = flush & (main_valid_r | skid_valid_r);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;
    assign occupancy = {1'b0, main_valid_r} + {1'b0, skid_valid_r};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps followed by random
// traffic, all compared against a FIFO-level reference model. A second
// instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_pipe_stage_reg;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt, flush_cnt;

    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occupancy;
    logic [3:0]    s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall(stall), .flush(flush), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .stall(stall), .flush(flush), .occupancy(s_occupancy),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Reference model: the stage is a FIFO of at most two beats.
    logic [DW-1:0] q[$];
    int m_stall = 0;
    int m_flush = 0;
    int n_pass  = 0;
    int n_total = 0;
    int s0, f0;

    function automatic logic [127:0] sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? 128'(mx) : 128'(v);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [DW-1:0] front;
        front = (q.size() > 0) ? q[0] : '0;
        chk("out_valid", out_valid, 128'(q.size() > 0));
        chk("out_data", out_data, front);
        chk("occupancy", occupancy, 128'(q.size()));
        chk("stall_cnt", stall_cnt, sat(m_stall, 16));
        chk("flush_cnt", flush_cnt, sat(m_flush, 16));
        chk("sat_out_data", s_out_data, front);
        chk("sat_occupancy", s_occupancy, 128'(q.size()));
        chk("sat_out_valid", s_out_valid, 128'(q.size() > 0));
        chk("sat_stall_cnt", s_stall_cnt, sat(m_stall, 4));
        chk("sat_flush_cnt", s_flush_cnt, sat(m_flush, 4));
    endtask

    // One clock cycle: drive inputs, check in_ready, step the model at the edge.
    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic st, input logic fl);
        logic m_rdy, m_dn, m_up;
        in_valid = iv; in_data = d; out_ready = ordy; stall = st; flush = fl;
        #1;
        m_rdy = (q.size() < 2);
        chk("in_ready", in_ready, 128'(m_rdy));
        chk("sat_in_ready", s_in_ready, 128'(m_rdy));
        m_dn = (q.size() > 0) && ordy && !st;
        m_up = iv && m_rdy;
        @(posedge clk);
        if ((q.size() > 0) && !m_dn) m_stall++;
        if (fl && (q.size() > 0)) m_flush++;
        if (m_dn) void'(q.pop_front());
        if (fl) q.delete();
        else if (m_up) q.push_back(d);
        #1;
        check_outputs();
    endtask

    initial begin
        // 1. Reset and empty.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_in_ready", in_ready, 128'd1);
        check_outputs();

        // 2. Streaming 0x1..0x8.
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
        chk("t2_last", out_data, 128'h8);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 3. Backpressure and skid.
        s0 = m_stall;
        cycle(1'b1, 128'hA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 128'hB, 1'b0, 1'b0, 1'b0);
        chk("t3_full_in_ready", in_ready, 128'd0);
        cycle(1'b1, 128'hC, 1'b0, 1'b0, 1'b0);
        chk("t3_head", out_data, 128'hA);
        chk("t3_stall_cnt", stall_cnt, 128'(s0 + 2));
        cycle(1'b1, 128'hC, 1'b1, 1'b0, 1'b0);
        chk("t3_second", out_data, 128'hB);
        cycle(1'b1, 128'hC, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 4. Flush with two held beats and a beat offered.
        cycle(1'b1, 128'h10, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 128'h11, 1'b0, 1'b0, 1'b0);
        chk("t4_occ2", occupancy, 128'd2);
        f0 = m_flush;
        cycle(1'b1, 128'h12, 1'b0, 1'b0, 1'b1);
        chk("t4_valid", out_valid, 128'd0);
        chk("t4_occ0", occupancy, 128'd0);
        chk("t4_flush_cnt", flush_cnt, 128'(f0 + 1));
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 5. Stall vs flush, then stall alone.
        cycle(1'b1, 128'h20, 1'b0, 1'b0, 1'b0);
        f0 = m_flush;
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("t5_killed", out_valid, 128'd0);
        chk("t5_flush_cnt", flush_cnt, 128'(f0 + 1));
        cycle(1'b1, 128'h20, 1'b1, 1'b0, 1'b0);
        s0 = m_stall;
        repeat (5) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("t5_stable", out_data, 128'h20);
        chk("t5_stall_cnt", stall_cnt, 128'(s0 + 5));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 6. Saturation, then asynchronous reset mid-cycle.
        cycle(1'b1, 128'h30, 1'b0, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("t6_sat", s_stall_cnt, 128'hF);
        in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 128'd0);
        chk("t6_rst_data", out_data, 128'd0);
        chk("t6_rst_occ", occupancy, 128'd0);
        chk("t6_rst_in_ready", in_ready, 128'd1);
        chk("t6_rst_stall", stall_cnt, 128'd0);
        chk("t6_rst_flush", flush_cnt, 128'd0);
        chk("t6_rst_sat", s_stall_cnt, 128'd0);
        q.delete();
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
